divider_seq_param: RTL and testbench

//  Parametrised multi-cycle non-restoring integer divider, successor to the fixed 32-bit divider.

---
 rtl/divider_seq_param.sv | 129 ++++++++++++
 tb/tb_divider_seq_param.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/divider_seq_param.sv
// Multi-cycle non-restoring divider, signed or unsigned per operation, with a start/ready handshake.
// Divide-by-zero and signed MIN/-1 take a short path that skips the iteration loop.
module divider_seq_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_div,
    input  logic             ctrl_signed,
    input  logic [WIDTH-1:0] data_A,
    input  logic [WIDTH-1:0] data_B,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_rdy,
    output logic             data_busy,
    output logic             data_exception,
    output logic             data_overflow
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_t;

    localparam logic [WIDTH-1:0] ONE_W   = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, q_reg, m_reg;
    logic             op_signed, sign_q, sign_r, exc_pend, ovf_pend;
    logic [WIDTH:0]   acc;
    logic [CNT_W-1:0] count;

    logic             a_neg, b_neg, div_zero, sgn_ovf;
    logic [WIDTH-1:0] abs_a, abs_b, rem_mag, quot, rem;
    logic [WIDTH:0]   shifted, acc_step;

    always_comb begin
        a_neg    = op_signed & op_a[WIDTH-1];
        b_neg    = op_signed & op_b[WIDTH-1];
        abs_a    = a_neg ? (~op_a + ONE_W) : op_a;
        abs_b    = b_neg ? (~op_b + ONE_W) : op_b;
        div_zero = (op_b == '0);
        sgn_ovf  = op_signed && (op_a == MIN_VAL) && (op_b == '1);
        // Add/subtract choice uses the partial remainder's sign before the shift.
        shifted  = {acc[WIDTH-1:0], q_reg[WIDTH-1]};
        acc_step = acc[WIDTH] ? (shifted + {1'b0, m_reg}) : (shifted - {1'b0, m_reg});
        rem_mag  = acc[WIDTH] ? (acc[WIDTH-1:0] + m_reg) : acc[WIDTH-1:0];
        quot     = sign_q ? (~q_reg + ONE_W) : q_reg;
        rem      = sign_r ? (~rem_mag + ONE_W) : rem_mag;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            op_a           <= '0;
            op_b           <= '0;
            op_signed      <= 1'b0;
            q_reg          <= '0;
            m_reg          <= '0;
            acc            <= '0;
            count          <= '0;
            sign_q         <= 1'b0;
            sign_r         <= 1'b0;
            exc_pend       <= 1'b0;
            ovf_pend       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_rdy       <= 1'b0;
            data_busy      <= 1'b0;
            data_exception <= 1'b0;
            data_overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ctrl_div) begin
                        op_a      <= data_A;
                        op_b      <= data_B;
                        op_signed <= ctrl_signed;
                        data_busy <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    sign_q         <= a_neg ^ b_neg;
                    sign_r         <= a_neg;
                    q_reg          <= abs_a;
                    m_reg          <= abs_b;
                    acc            <= '0;
                    count          <= '0;
                    exc_pend       <= div_zero;
                    ovf_pend       <= sgn_ovf;
                    data_exception <= 1'b0;
                    data_overflow  <= 1'b0;
                    // Special cases go through FIX too, so every result registers one cycle later.
                    state          <= (div_zero || sgn_ovf) ? S_FIX : S_RUN;
                end
                S_RUN: begin
                    acc   <= acc_step;
                    q_reg <= {q_reg[WIDTH-2:0], ~acc_step[WIDTH]};
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    if (exc_pend) begin
                        data_result    <= '1;
                        data_remainder <= op_a;
                    end else if (ovf_pend) begin
                        data_result    <= MIN_VAL;
                        data_remainder <= '0;
                    end else begin
                        data_result    <= quot;
                        data_remainder <= rem;
                    end
                    data_exception <= exc_pend;
                    data_overflow  <= ovf_pend;
                    data_rdy       <= 1'b1;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    data_rdy  <= 1'b0;
                    data_busy <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_param.sv
// Bench for divider_seq_param: 32-bit and 8-bit instances checked every cycle against an arithmetic model,
// plus directed vectors with hand-computed results and latencies.
module tb_divider_seq_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        div32, sgn32, div8, sgn8;
    logic [31:0] a32, b32, res32, rem32;
    logic [7:0]  a8, b8, res8, rem8;
    logic        rdy32, busy32, exc32, ovf32, rdy8, busy8, exc8, ovf8;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    divider_seq_param #(.WIDTH(32)) dut32 (
        .clock(clock), .reset(reset), .ctrl_div(div32), .ctrl_signed(sgn32),
        .data_A(a32), .data_B(b32), .data_result(res32), .data_remainder(rem32),
        .data_rdy(rdy32), .data_busy(busy32), .data_exception(exc32), .data_overflow(ovf32));

    divider_seq_param #(.WIDTH(8)) dut8 (
        .clock(clock), .reset(reset), .ctrl_div(div8), .ctrl_signed(sgn8),
        .data_A(a8), .data_B(b8), .data_result(res8), .data_remainder(rem8),
        .data_rdy(rdy8), .data_busy(busy8), .data_exception(exc8), .data_overflow(ovf8));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: plain integer division with truncation toward zero, plus the two special cases.
    function automatic void ref_div(input int w, input logic [63:0] a, input logic [63:0] b, input bit s,
                                    output logic [63:0] q, output logic [63:0] r,
                                    output bit exc, output bit ovf, output int lat);
        logic [63:0] mask;
        longint      sa, sb;
        mask = (64'd1 << w) - 64'd1;
        sa   = longint'(a << (64 - w)) >>> (64 - w);
        sb   = longint'(b << (64 - w)) >>> (64 - w);
        exc  = 1'b0;
        ovf  = 1'b0;
        lat  = w + 2;
        if (b == 64'd0) begin
            exc = 1'b1; q = mask; r = a; lat = 2;
        end else if (s && sa == -(longint'(1) << (w - 1)) && sb == -1) begin
            ovf = 1'b1; q = 64'd1 << (w - 1); r = 64'd0; lat = 2;
        end else if (s) begin
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Model of what each instance shows in every cycle; index 0 = 32-bit, 1 = 8-bit.
    logic [63:0] m_res[2], m_rem[2], p_res[2], p_rem[2];
    bit          m_exc[2], m_ovf[2], p_exc[2], p_ovf[2], m_act[2];
    int          m_k[2], m_rdy[2];
    bit          armed = 1'b0;
    int          cyc = 0;
    logic [63:0] g_res, g_rem, i_a, i_b;
    logic        g_rdy, g_busy, g_exc, g_ovf, i_div, i_sgn;
    int          g_w, g_lat;
    string       tag;

    initial begin : compare
        for (int d = 0; d < 2; d++) begin
            m_res[d] = '0; m_rem[d] = '0; m_exc[d] = 0; m_ovf[d] = 0; m_act[d] = 0;
            m_k[d] = 0; m_rdy[d] = 0;
        end
        forever begin
            @(negedge clock);
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    tag = "w32"; g_w = 32;
                    g_res = {32'b0, res32}; g_rem = {32'b0, rem32};
                    g_rdy = rdy32; g_busy = busy32; g_exc = exc32; g_ovf = ovf32;
                    i_div = div32; i_sgn = sgn32; i_a = {32'b0, a32}; i_b = {32'b0, b32};
                end else begin
                    tag = "w8"; g_w = 8;
                    g_res = {56'b0, res8}; g_rem = {56'b0, rem8};
                    g_rdy = rdy8; g_busy = busy8; g_exc = exc8; g_ovf = ovf8;
                    i_div = div8; i_sgn = sgn8; i_a = {56'b0, a8}; i_b = {56'b0, b8};
                end
                if (armed) begin
                    chk({tag, " rdy"}, {63'b0, g_rdy}, {63'b0, m_act[d] && cyc == m_rdy[d]});
                    chk({tag, " busy"}, {63'b0, g_busy},
                        {63'b0, m_act[d] && cyc >= m_k[d] && cyc <= m_rdy[d]});
                    chk({tag, " result"}, g_res, m_res[d]);
                    chk({tag, " remainder"}, g_rem, m_rem[d]);
                    chk({tag, " exception"}, {63'b0, g_exc}, {63'b0, m_exc[d]});
                    chk({tag, " overflow"}, {63'b0, g_ovf}, {63'b0, m_ovf[d]});
                end
                // Advance the model across the coming rising edge (edge number cyc+1).
                if (reset) begin
                    m_act[d] = 0; m_res[d] = '0; m_rem[d] = '0; m_exc[d] = 0; m_ovf[d] = 0;
                end else begin
                    if (m_act[d] && cyc + 1 == m_k[d] + 1) begin
                        m_exc[d] = 0; m_ovf[d] = 0;
                    end
                    if (m_act[d] && cyc + 1 == m_rdy[d]) begin
                        m_res[d] = p_res[d]; m_rem[d] = p_rem[d];
                        m_exc[d] = p_exc[d]; m_ovf[d] = p_ovf[d];
                    end
                    if ((!m_act[d] || cyc > m_rdy[d]) && i_div) begin
                        ref_div(g_w, i_a, i_b, i_sgn, p_res[d], p_rem[d], p_exc[d], p_ovf[d], g_lat);
                        m_act[d] = 1;
                        m_k[d]   = cyc + 1;
                        m_rdy[d] = cyc + 1 + g_lat;
                    end
                end
            end
            if (reset) armed = 1'b1;
        end
    end

    task automatic wait_rdy(input bit w8, input int limit, output int off);
        off = -1;
        for (int i = 0; i <= limit; i++) begin
            @(negedge clock);
            if ((w8 ? rdy8 : rdy32) === 1'b1) begin
                off = i;
                break;
            end
        end
    endtask

    task automatic start32(input logic [31:0] a, input logic [31:0] b, input bit s);
        @(posedge clock); #2;
        a32 = a; b32 = b; sgn32 = s; div32 = 1'b1;
        @(posedge clock); #2;
        div32 = 1'b0; a32 = $urandom; b32 = $urandom; sgn32 = 1'($urandom_range(0, 1));
    endtask

    task automatic start8(input logic [7:0] a, input logic [7:0] b, input bit s);
        @(posedge clock); #2;
        a8 = a; b8 = b; sgn8 = s; div8 = 1'b1;
        @(posedge clock); #2;
        div8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sgn8 = 1'($urandom_range(0, 1));
    endtask

    task automatic op32(input string name, input logic [31:0] a, input logic [31:0] b, input bit s,
                        input logic [31:0] eq, input logic [31:0] er, input bit eexc, input bit eovf,
                        input int elat);
        int off;
        start32(a, b, s);
        wait_rdy(1'b0, 60, off);
        chk({name, " latency"}, 64'(off), 64'(elat));
        chk({name, " quotient"}, {32'b0, res32}, {32'b0, eq});
        chk({name, " remainder"}, {32'b0, rem32}, {32'b0, er});
        chk({name, " exc"}, {63'b0, exc32}, {63'b0, eexc});
        chk({name, " ovf"}, {63'b0, ovf32}, {63'b0, eovf});
    endtask

    task automatic op8(input string name, input logic [7:0] a, input logic [7:0] b, input bit s,
                       input logic [7:0] eq, input logic [7:0] er, input bit eexc, input bit eovf,
                       input int elat);
        int off;
        start8(a, b, s);
        wait_rdy(1'b1, 30, off);
        chk({name, " latency"}, 64'(off), 64'(elat));
        chk({name, " quotient"}, {56'b0, res8}, {56'b0, eq});
        chk({name, " remainder"}, {56'b0, rem8}, {56'b0, er});
        chk({name, " exc"}, {63'b0, exc8}, {63'b0, eexc});
        chk({name, " ovf"}, {63'b0, ovf8}, {63'b0, eovf});
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] q, r;
        bit          e, o;
        int          lat, off;
        logic [7:0]  ra, rb;
        bit          rs;

        reset = 1'b1;
        div32 = 0; sgn32 = 0; a32 = '0; b32 = '0;
        div8  = 0; sgn8  = 0; a8  = '0; b8  = '0;

        // Pin the model against hand-computed values.
        ref_div(32, 64'hFFFF_FF9C, 64'd7, 1'b1, q, r, e, o, lat);
        chk("model -100/7 q", q, 64'hFFFF_FFF2);
        chk("model -100/7 r", r, 64'hFFFF_FFFE);
        ref_div(8, 64'h80, 64'h03, 1'b1, q, r, e, o, lat);
        chk("model -128/3 q", q, 64'hD6);
        chk("model -128/3 r", r, 64'hFE);
        chk("model w8 latency", 64'(lat), 64'd10);
        ref_div(32, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, q, r, e, o, lat);
        chk("model ovf flag", {63'b0, o}, 64'd1);
        chk("model ovf q", q, 64'h8000_0000);

        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        @(negedge clock);
        chk("reset rdy", {63'b0, rdy32}, 64'd0);
        chk("reset busy", {63'b0, busy32}, 64'd0);
        chk("reset result", {32'b0, res32}, 64'd0);
        chk("reset rem8", {56'b0, rem8}, 64'd0);

        op32("u 100/7",      32'd100,        32'd7,          0, 32'd14,         32'd2,          0, 0, 34);
        op32("s -100/7",     32'hFFFF_FF9C,  32'd7,          1, 32'hFFFF_FFF2,  32'hFFFF_FFFE,  0, 0, 34);
        op32("s 100/-7",     32'd100,        32'hFFFF_FFF9,  1, 32'hFFFF_FFF2,  32'd2,          0, 0, 34);
        op32("s -100/-7",    32'hFFFF_FF9C,  32'hFFFF_FFF9,  1, 32'd14,         32'hFFFF_FFFE,  0, 0, 34);
        op32("5/0",          32'd5,          32'd0,          0, 32'hFFFF_FFFF,  32'd5,          1, 0, 2);
        op32("s -5/0",       32'hFFFF_FFFB,  32'd0,          1, 32'hFFFF_FFFF,  32'hFFFF_FFFB,  1, 0, 2);
        op32("s MIN/-1",     32'h8000_0000,  32'hFFFF_FFFF,  1, 32'h8000_0000,  32'd0,          0, 1, 2);
        op32("u MIN/ones",   32'h8000_0000,  32'hFFFF_FFFF,  0, 32'd0,          32'h8000_0000,  0, 0, 34);
        op32("u max/max",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, 32'd1,          32'd0,          0, 0, 34);
        op32("s MIN/3",      32'h8000_0000,  32'd3,          1, 32'hD555_5556,  32'hFFFF_FFFE,  0, 0, 34);

        op8("w8 u 255/1",    8'hFF, 8'h01, 0, 8'hFF, 8'h00, 0, 0, 10);
        op8("w8 s -128/3",   8'h80, 8'h03, 1, 8'hD6, 8'hFE, 0, 0, 10);
        op8("w8 s -128/-1",  8'h80, 8'hFF, 1, 8'h80, 8'h00, 0, 1, 2);
        op8("w8 u 7/9",      8'h07, 8'h09, 0, 8'h00, 8'h07, 0, 0, 10);

        // Start held high through the busy and DONE cycles: the next start lands on the first IDLE cycle.
        @(posedge clock); #2;
        a32 = 32'd100; b32 = 32'd7; sgn32 = 0; div32 = 1'b1;
        @(posedge clock); #2;
        wait_rdy(1'b0, 60, off);
        chk("held first rdy", 64'(off), 64'd34);
        wait_rdy(1'b0, 60, off);
        chk("held second rdy", 64'(off), 64'd35);
        chk("held second q", {32'b0, res32}, 64'd14);
        @(posedge clock); #2;
        div32 = 1'b0;

        // Reset in the middle of RUN aborts with no ready pulse.
        start32(32'd1000, 32'd3, 0);
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #2 reset = 1'b0;
        wait_rdy(1'b0, 40, off);
        chk("abort no rdy", 64'(off), -64'sd1);
        chk("abort result", {32'b0, res32}, 64'd0);
        chk("abort busy", {63'b0, busy32}, 64'd0);

        // Reset and start together: the start is dropped.
        @(posedge clock); #2;
        reset = 1'b1; div32 = 1'b1; a32 = 32'd9; b32 = 32'd2;
        @(posedge clock); #2;
        reset = 1'b0; div32 = 1'b0;
        wait_rdy(1'b0, 40, off);
        chk("reset+start dropped", 64'(off), -64'sd1);

        op32("after reset 9/2", 32'd9, 32'd2, 0, 32'd4, 32'd1, 0, 0, 34);

        for (int n = 0; n < 5000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) rb = 8'h00;
            if ($urandom_range(0, 15) == 0) begin ra = 8'h80; rb = 8'hFF; end
            ref_div(8, {56'b0, ra}, {56'b0, rb}, rs, q, r, e, o, lat);
            start8(ra, rb, rs);
            wait_rdy(1'b1, 30, off);
            chk("w8 random latency", 64'(off), 64'(lat));
        end

        repeat (5) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
